pipe_skid_reg: RTL

//   Elastic pipeline register slice with a 2-entry skid buffer and a valid/ready handshake on both sides.
//   It is the handshaked successor to the plain enable flop used between rv32 pipeline stages.

---
 rtl/pipe_skid_reg.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic pipeline register slice with a 2-entry skid buffer.
// Valid/ready on both sides; in_ready_o depends only on state and rst, so
// there is no combinational path from out_ready_i back to in_ready_o.
// Optional feature macro: PIPE_SKID_STALL_CNT_EN enables the saturating
// backpressure counter on stall_cnt_o (tied to 0 otherwise).
//
// Handshake: a beat transfers on a rising edge where valid=1 and ready=1;
// valid must not depend on ready, and data/valid hold until the transfer.
// occ_o is the FSM state encoding (EMPTY=0, ONE=1, FULL=2).
module pipe_skid_reg #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       occ_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             w_push;
  logic             w_pop;

  assign in_ready_o  = (r_state != S_FULL) & ~rst;
  assign out_valid_o = (r_state != S_EMPTY);
  assign out_data_o  = r_main;
  assign occ_o       = r_state;

  assign w_push = in_valid_i & in_ready_o;
  assign w_pop  = out_valid_o & out_ready_i;

  // Next-state and data-register loads; flush empties the slice and drops the push.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush_i) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_push) begin
            w_state_nxt = S_ONE;
            w_main_nxt  = in_data_i;
          end
        end
        S_ONE: begin
          if (w_push && w_pop) begin
            w_main_nxt = in_data_i;
          end else if (w_push) begin
            w_state_nxt = S_FULL;
            w_skid_nxt  = in_data_i;
          end else if (w_pop) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          // in_ready_o is 0 here, so only a pop can move the slice.
          if (w_pop) begin
            w_state_nxt = S_ONE;
            w_main_nxt  = r_skid;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  // State and data registers; rst overrides flush and any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_main  <= RST_VAL;
      r_skid  <= RST_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Count edges with a held output under backpressure; saturate, clear only on rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (out_valid_o && !out_ready_i && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
